reg_file_sb: RTL

//   Parametrised successor register file for the datapath: NR combinational read ports,
//   two write ports (A = ALU writeback, B = load writeback), optional write-to-read bypass,

---
 rtl/reg_file_sb_pkg.sv | 22 ++
 rtl/reg_file_sb_if.sv | 39 +++
 rtl/reg_file_sb_scoreboard.sv | 62 ++++++
 rtl/reg_file_sb.sv | 93 +++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared types and helpers for the scoreboarded register file.
// Holds default widths, word/address types and the write-hit test.
package rf_pkg;

  localparam int RF_W    = 8;
  localparam int RF_A    = 4;
  localparam int RF_AMAX = 16;

  typedef logic [RF_W-1:0] rf_word_t;
  typedef logic [RF_A-1:0] rf_addr_t;

  // True when an enabled write port targets addr; addresses are
  // zero-extended by the caller so any A up to RF_AMAX fits.
  function automatic logic rf_wr_hit(
    input logic [RF_AMAX-1:0] addr,
    input logic               en,
    input logic [RF_AMAX-1:0] waddr
  );
    return en && (addr == waddr);
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus of the register file.
// master: decode+writeback side, slave: register file.
interface reg_file_sb_if
  import rf_pkg::*;
#(
  parameter int W  = RF_W,
  parameter int A  = RF_A,
  parameter int NR = 2
);

  logic [NR*A-1:0] Raddr;
  logic [NR*W-1:0] DataOut;
  logic [NR-1:0]   RBusy;
  logic            WriteEnA;
  logic [A-1:0]    WaddrA;
  logic [W-1:0]    DataInA;
  logic            WriteEnB;
  logic [A-1:0]    WaddrB;
  logic [W-1:0]    DataInB;
  logic            IssueEn;
  logic [A-1:0]    IssueAddr;
  logic [2**A-1:0] BusyVec;
  logic            WConflict;

  modport master (
    output Raddr, WriteEnA, WaddrA, DataInA,
    output WriteEnB, WaddrB, DataInB,
    output IssueEn, IssueAddr,
    input  DataOut, RBusy, BusyVec, WConflict
  );

  modport slave (
    input  Raddr, WriteEnA, WaddrA, DataInA,
    input  WriteEnB, WaddrB, DataInB,
    input  IssueEn, IssueAddr,
    output DataOut, RBusy, BusyVec, WConflict
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy bits: issue sets, write clears, issue wins.
// Ports: clk/reset, issue, filtered write enables, read addrs, busy outs.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int A       = RF_A,
  parameter int NR      = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_en,
  input  logic [A-1:0]    issue_addr,
  input  logic            we_a,
  input  logic [A-1:0]    waddr_a,
  input  logic            we_b,
  input  logic [A-1:0]    waddr_b,
  input  logic [NR*A-1:0] raddr,
  output logic [2**A-1:0] busy_vec,
  output logic [NR-1:0]   rbusy
);

  localparam int D = 2**A;

  logic iss;

  assign iss = issue_en &&
               !((ZERO_R0 != 0) && (issue_addr == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_vec <= '0;
    end else begin
      for (int r = 0; r < D; r++) begin
        if (iss && (issue_addr == A'(r)))
          busy_vec[r] <= 1'b1;
        else if (rf_wr_hit(RF_AMAX'(r), we_a,
                           RF_AMAX'(waddr_a)) ||
                 rf_wr_hit(RF_AMAX'(r), we_b,
                           RF_AMAX'(waddr_b)))
          busy_vec[r] <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rb
    logic [A-1:0] ra;
    logic         fwd;
    logic         zero;
    assign ra   = raddr[i*A +: A];
    // A forwarded value is already complete, so no stall.
    assign fwd  = (BYPASS != 0) &&
                  (rf_wr_hit(RF_AMAX'(ra), we_a,
                             RF_AMAX'(waddr_a)) ||
                   rf_wr_hit(RF_AMAX'(ra), we_b,
                             RF_AMAX'(waddr_b)));
    assign zero = (ZERO_R0 != 0) && (ra == '0);
    assign rbusy[i] = busy_vec[ra] && !fwd && !zero;
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two write ports, bypass, optional zero R0 and
// busy scoreboard. Ports: Clk, Reset, bus (reg_file_sb_if.slave).
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int W       = RF_W,
  parameter int A       = RF_A,
  parameter int NR      = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic         Clk,
  input  logic         Reset,
  reg_file_sb_if.slave bus
);

  localparam int D = 2**A;

  logic [W-1:0] mem [D];
  logic         wr_a;
  logic         wr_b;
  logic         same;
  logic         keep_a;
  logic         wconf;

  // Writes to a hardwired R0 vanish before arbitration.
  assign wr_a = bus.WriteEnA &&
                !((ZERO_R0 != 0) && (bus.WaddrA == '0));
  assign wr_b = bus.WriteEnB &&
                !((ZERO_R0 != 0) && (bus.WaddrB == '0));
  assign same   = bus.WaddrA == bus.WaddrB;
  assign keep_a = wr_a && !(wr_b && same);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int r = 0; r < D; r++)
        mem[r] <= '0;
      wconf <= 1'b0;
    end else begin
      if (keep_a)
        mem[bus.WaddrA] <= bus.DataInA;
      if (wr_b)
        mem[bus.WaddrB] <= bus.DataInB;
      wconf <= wr_a && wr_b && same;
    end
  end

  assign bus.WConflict = wconf;

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [A-1:0] ra;
    logic         hit_a;
    logic         hit_b;
    logic         zero;
    logic [W-1:0] dout;
    assign ra    = bus.Raddr[i*A +: A];
    assign hit_a = (BYPASS != 0) &&
                   rf_wr_hit(RF_AMAX'(ra), wr_a,
                             RF_AMAX'(bus.WaddrA));
    assign hit_b = (BYPASS != 0) &&
                   rf_wr_hit(RF_AMAX'(ra), wr_b,
                             RF_AMAX'(bus.WaddrB));
    assign zero  = (ZERO_R0 != 0) && (ra == '0);
    // Port B has priority, matching the commit rule.
    always_comb begin
      dout = mem[ra];
      if (hit_a) dout = bus.DataInA;
      if (hit_b) dout = bus.DataInB;
      if (zero)  dout = '0;
    end
    assign bus.DataOut[i*W +: W] = dout;
  end

  rf_scoreboard #(
    .A       (A),
    .NR      (NR),
    .BYPASS  (BYPASS),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk        (Clk),
    .reset      (Reset),
    .issue_en   (bus.IssueEn),
    .issue_addr (bus.IssueAddr),
    .we_a       (wr_a),
    .waddr_a    (bus.WaddrA),
    .we_b       (wr_b),
    .waddr_b    (bus.WaddrB),
    .raddr      (bus.Raddr),
    .busy_vec   (bus.BusyVec),
    .rbusy      (bus.RBusy)
  );

endmodule
